pc_fetch_unit: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives instruction-memory

---
 rtl/pc_fetch_unit_pkg.sv | 28 ++
 rtl/pfu_next_pc.sv | 63 ++++++
 rtl/pc_fetch_unit.sv | 77 +++++++
 tb/tb_pc_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared next-PC select codes and reset/flush constants for the IF stage.
package pc_fetch_unit_pkg;

  localparam int unsigned PFU_OP_LENGTH = 3;

  typedef enum logic [PFU_OP_LENGTH-1:0] {
    PFU_OP_NEXT      = 3'd0,
    PFU_OP_OFFSET_16 = 3'd1,
    PFU_OP_OFFSET_26 = 3'd2,
    PFU_OP_JUMP      = 3'd3,
    PFU_OP_RS        = 3'd4
  } pfu_op_e;

  localparam logic [31:0] PFU_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] PFU_NOP_INSTR = 32'h0000_0000;

  // Shift a sign-extended word offset into a byte offset.
  function automatic logic [31:0] pfu_word_offset(input logic [25:0] off, input logic wide);
    logic [31:0] w_res;
    if (wide) begin
      w_res = {{4{off[25]}}, off[25:0], 2'b00};
    end else begin
      w_res = {{14{off[15]}}, off[15:0], 2'b00};
    end
    return w_res;
  endfunction

endpackage

// File: rtl/pfu_next_pc.sv
// Next-PC target mux and alignment check for the fetch unit.
module pfu_next_pc
  import pc_fetch_unit_pkg::*;
(
  input  logic [PFU_OP_LENGTH-1:0] i_pc_src,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_id_pc,
  input  logic [25:0]              i_id_index,
  input  logic                     i_id_valid,
  input  logic [31:0]              i_rs_data,
  output logic [31:0]              o_next_pc,
  output logic                     o_redirect,
  output logic                     o_misaligned,
  output logic                     o_squash
);

  logic [31:0] w_pc4;
  logic [31:0] w_seq;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_squash;

  assign w_pc4 = i_id_pc + 32'd4;
  assign w_seq = i_pc + 32'd4;

  always_comb begin
    w_target   = w_seq;
    w_redirect = 1'b0;
    w_squash   = 1'b0;
    // A flushed slot carries no real branch, so it can never redirect.
    if (i_id_valid) begin
      case (i_pc_src)
        PFU_OP_OFFSET_16: begin
          w_target   = w_pc4 + pfu_word_offset(i_id_index, 1'b0);
          w_redirect = 1'b1;
        end
        PFU_OP_OFFSET_26: begin
          w_target   = w_pc4 + pfu_word_offset(i_id_index, 1'b1);
          w_redirect = 1'b1;
          w_squash   = 1'b1;
        end
        PFU_OP_JUMP: begin
          w_target   = {w_pc4[31:28], i_id_index, 2'b00};
          w_redirect = 1'b1;
        end
        PFU_OP_RS: begin
          w_target   = i_rs_data;
          w_redirect = 1'b1;
        end
        default: begin
          w_target   = w_seq;
          w_redirect = 1'b0;
        end
      endcase
    end
  end

  assign o_next_pc    = {w_target[31:2], 2'b00};
  assign o_redirect   = w_redirect;
  assign o_misaligned = w_redirect & (w_target[1:0] != 2'b00);
  assign o_squash     = w_squash;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, IF/ID pipeline register and sticky fetch error flag.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PFU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PFU_NOP_INSTR
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [PFU_OP_LENGTH-1:0] i_pc_src,
  input  logic                     i_stall,
  input  logic [31:0]              i_rs_data,
  input  logic [31:0]              i_imem_rdata,
  output logic [31:0]              o_imem_addr,
  output logic [31:0]              o_id_instr,
  output logic [31:0]              o_id_pc,
  output logic [31:0]              o_id_pc_plus8,
  output logic                     o_id_valid,
  output logic                     o_fetch_err
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_fetch_err;

  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_misaligned;
  logic        w_squash;

  pfu_next_pc u_next_pc (
    .i_pc_src     (i_pc_src),
    .i_pc         (r_pc),
    .i_id_pc      (r_id_pc),
    .i_id_index   (r_id_instr[25:0]),
    .i_id_valid   (r_id_valid),
    .i_rs_data    (i_rs_data),
    .o_next_pc    (w_next_pc),
    .o_redirect   (w_redirect),
    .o_misaligned (w_misaligned),
    .o_squash     (w_squash)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc        <= RESET_PC;
      r_id_instr  <= NOP_INSTR;
      r_id_pc     <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else if (!i_stall) begin
      r_pc    <= w_next_pc;
      r_id_pc <= r_pc;
      // Compact branches have no delay slot: the fetched word is dropped.
      if (w_squash) begin
        r_id_instr <= NOP_INSTR;
        r_id_valid <= 1'b0;
      end else begin
        r_id_instr <= i_imem_rdata;
        r_id_valid <= 1'b1;
      end
      if (w_redirect && w_misaligned) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_id_instr    = r_id_instr;
  assign o_id_pc       = r_id_pc;
  assign o_id_pc_plus8 = r_id_pc + 32'd8;
  assign o_id_valid    = r_id_valid;
  assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small table-driven instruction memory.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic                     clk;
  logic                     rst;
  logic [PFU_OP_LENGTH-1:0] pc_src;
  logic                     stall;
  logic [31:0]              rs_data;
  logic [31:0]              imem_rdata;
  logic [31:0]              imem_addr;
  logic [31:0]              id_instr;
  logic [31:0]              id_pc;
  logic [31:0]              id_pc_plus8;
  logic                     id_valid;
  logic                     fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] imem [64];

  pc_fetch_unit dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pc_src      (pc_src),
    .i_stall       (stall),
    .i_rs_data     (rs_data),
    .i_imem_rdata  (imem_rdata),
    .o_imem_addr   (imem_addr),
    .o_id_instr    (id_instr),
    .o_id_pc       (id_pc),
    .o_id_pc_plus8 (id_pc_plus8),
    .o_id_valid    (id_valid),
    .o_fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (a[31:8] == 24'h000030) return imem[a[7:2]];
    return {8'hEE, a[23:0]};
  endfunction

  assign imem_rdata = fetch_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h2400_0000 | i;
    imem[0] = 32'hC800_0010; // BC off26=0x10
    imem[4] = 32'h1000_FFFF; // BEQ imm16=0xFFFF
    imem[5] = 32'h2401_0005; // delay-slot word
    rst     = 1'b1;
    pc_src  = PFU_OP_NEXT;
    stall   = 1'b0;
    rs_data = '0;
    #2;
    check_eq("rst_addr", imem_addr, 32'h0000_3000);
    check_eq("rst_instr", id_instr, 32'h0);
    check_eq("rst_id_pc", id_pc, 32'h0000_3000);
    check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch; ID lags IF by one cycle.
    step();
    check_eq("seq1_addr", imem_addr, 32'h0000_3004);
    check_eq("seq1_id_pc", id_pc, 32'h0000_3000);
    check_eq("seq1_valid", {31'b0, id_valid}, 32'd1);
    check_eq("seq1_instr", id_instr, 32'hC800_0010);
    step();
    check_eq("seq2_addr", imem_addr, 32'h0000_3008);
    check_eq("seq2_id_pc", id_pc, 32'h0000_3004);
    step();
    step();
    step();
    check_eq("seq5_addr", imem_addr, 32'h0000_3014);
    check_eq("seq5_instr", id_instr, 32'h1000_FFFF);

    // BEQ back to itself; delay slot kept.
    pc_src = PFU_OP_OFFSET_16;
    step();
    check_eq("beq_addr", imem_addr, 32'h0000_3010);
    check_eq("beq_id_pc", id_pc, 32'h0000_3014);
    check_eq("beq_instr", id_instr, 32'h2401_0005);
    check_eq("beq_valid", {31'b0, id_valid}, 32'd1);
    check_eq("beq_plus8", id_pc_plus8, 32'h0000_301C);

    // JR to misaligned target: sticky error, PC aligned down.
    pc_src  = PFU_OP_RS;
    rs_data = 32'h0000_3402;
    step();
    check_eq("jr_addr", imem_addr, 32'h0000_3400);
    check_eq("jr_err", {31'b0, fetch_err}, 32'd1);
    check_eq("jr_id_pc", id_pc, 32'h0000_3010);
    pc_src = PFU_OP_NEXT;
    step();
    step();
    check_eq("jr_next_addr", imem_addr, 32'h0000_3408);
    check_eq("err_sticky", {31'b0, fetch_err}, 32'd1);

    // Asynchronous reset mid-run.
    rst = 1'b1;
    #1;
    check_eq("amid_addr", imem_addr, 32'h0000_3000);
    check_eq("amid_valid", {31'b0, id_valid}, 32'd0);
    check_eq("amid_err", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // BC: slot squashed, then a redirect from the flushed NOP is ignored.
    step();
    check_eq("bc_pre_id_pc", id_pc, 32'h0000_3000);
    pc_src = PFU_OP_OFFSET_26;
    step();
    check_eq("bc_addr", imem_addr, 32'h0000_3044);
    check_eq("bc_valid", {31'b0, id_valid}, 32'd0);
    check_eq("bc_instr", id_instr, 32'h0);
    pc_src = PFU_OP_OFFSET_16;
    step();
    check_eq("nop_noredir_addr", imem_addr, 32'h0000_3048);
    check_eq("nop_noredir_valid", {31'b0, id_valid}, 32'd1);
    check_eq("nop_noredir_instr", id_instr, 32'h2400_0011);

    // Stall holds everything, then the jump is taken.
    imem[0] = 32'h0800_0C40; // J to 0x3100
    pc_src  = PFU_OP_NEXT;
    pulse_reset();
    step();
    check_eq("j_pre_instr", id_instr, 32'h0800_0C40);
    stall  = 1'b1;
    pc_src = PFU_OP_JUMP;
    step();
    step();
    check_eq("stall_addr", imem_addr, 32'h0000_3004);
    check_eq("stall_id_pc", id_pc, 32'h0000_3000);
    check_eq("stall_instr", id_instr, 32'h0800_0C40);
    check_eq("stall_valid", {31'b0, id_valid}, 32'd1);
    stall = 1'b0;
    step();
    check_eq("j_addr", imem_addr, 32'h0000_3100);
    check_eq("j_id_pc", id_pc, 32'h0000_3004);

    // Wrap at the top of the address space.
    pc_src  = PFU_OP_RS;
    rs_data = 32'hFFFF_FFFC;
    step();
    check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
    check_eq("top_err", {31'b0, fetch_err}, 32'd0);
    pc_src = PFU_OP_NEXT;
    step();
    check_eq("wrap_addr", imem_addr, 32'h0000_0000);
    check_eq("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_plus8", id_pc_plus8, 32'h0000_0004);
    check_eq("wrap_instr", id_instr, 32'hEEFF_FFFC);

    // Undefined select code behaves as sequential.
    pc_src = 3'd7;
    step();
    check_eq("undef_addr", imem_addr, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
